// File: rtl/icu_issue_scheduler.sv
// icu_issue_scheduler: single-entry hazard-checking issue stage in front of the ICU dispatcher.
// Ports: clk, rst | in_valid/in_instr/in_ready (upstream) | issue_valid/issue_instr (dispatcher)
//        | illegal_op pulse | idle | stall_cycles (saturating hazard-stall counter).
module icu_issue_scheduler #(
    parameter int INSTR_WIDTH     = 32,
    parameter int NUM_STREAM_ID   = 5,
    parameter int MEM_RD_LATENCY  = 4,
    parameter int VXM_LATENCY     = 3,
    parameter int STALL_CNT_WIDTH = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    input  logic [INSTR_WIDTH-1:0]     in_instr,
    output logic                       in_ready,
    output logic                       issue_valid,
    output logic [INSTR_WIDTH-1:0]     issue_instr,
    output logic                       illegal_op,
    output logic                       idle,
    output logic [STALL_CNT_WIDTH-1:0] stall_cycles
);

    localparam int NUM_STREAMS = 1 << NUM_STREAM_ID;
    localparam logic [3:0] RD_LOAD  = 4'(MEM_RD_LATENCY);
    localparam logic [3:0] ADD_LOAD = 4'(VXM_LATENCY);
    localparam logic [7:0] OP_READ  = 8'h01;
    localparam logic [7:0] OP_ADD   = 8'h03;
    localparam logic [7:0] OP_WRITE = 8'h04;
    localparam logic [STALL_CNT_WIDTH-1:0] STALL_ONE =
        {{(STALL_CNT_WIDTH-1){1'b0}}, 1'b1};

    typedef logic [NUM_STREAM_ID-1:0] sid_t;

    logic                   hold_valid;
    logic [INSTR_WIDTH-1:0] hold_instr;
    logic [3:0]             cnt [NUM_STREAMS];
    logic [NUM_STREAMS-1:0] busy;

    logic [7:0] opcode;
    logic       is_read;
    logic       is_add;
    logic       is_write;
    sid_t       f_src1;
    sid_t       f_src2;
    sid_t       f_add_dest;
    sid_t       f_rw;

    logic       hazard;
    logic       legal;
    logic       load_en;
    sid_t       load_idx;
    logic [3:0] load_val;
    logic       can_go;
    logic       accept;

    assign opcode     = hold_instr[INSTR_WIDTH-1 -: 8];
    assign is_read    = (opcode == OP_READ);
    assign is_add     = (opcode == OP_ADD);
    assign is_write   = (opcode == OP_WRITE);
    assign f_src1     = hold_instr[0 +: NUM_STREAM_ID];
    assign f_src2     = hold_instr[5 +: NUM_STREAM_ID];
    assign f_add_dest = hold_instr[10 +: NUM_STREAM_ID];
    // Read dest and Write src share the same field.
    assign f_rw       = hold_instr[9 +: NUM_STREAM_ID];

    always_comb begin
        for (int i = 0; i < NUM_STREAMS; i++) begin
            busy[i] = |cnt[i];
        end
    end

    always_comb begin
        hazard   = 1'b0;
        legal    = 1'b0;
        load_en  = 1'b0;
        load_idx = '0;
        load_val = '0;
        unique case (1'b1)
            is_read: begin
                legal    = 1'b1;
                hazard   = busy[f_rw];
                load_en  = 1'b1;
                load_idx = f_rw;
                load_val = RD_LOAD;
            end
            is_add: begin
                legal    = 1'b1;
                hazard   = busy[f_src1] | busy[f_src2] | busy[f_add_dest];
                load_en  = 1'b1;
                load_idx = f_add_dest;
                load_val = ADD_LOAD;
            end
            is_write: begin
                legal  = 1'b1;
                hazard = busy[f_rw];
            end
            default: begin
                legal  = 1'b0;
                hazard = 1'b0;
            end
        endcase
    end

    assign can_go   = hold_valid & ~hazard;
    assign in_ready = ~hold_valid | can_go;
    assign accept   = in_valid & in_ready;
    assign idle     = ~hold_valid & ~|busy;

    always_ff @(posedge clk) begin
        if (rst) begin
            hold_valid   <= 1'b0;
            hold_instr   <= '0;
            issue_valid  <= 1'b0;
            issue_instr  <= '0;
            illegal_op   <= 1'b0;
            stall_cycles <= '0;
            for (int i = 0; i < NUM_STREAMS; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            issue_valid <= 1'b0;
            illegal_op  <= 1'b0;

            for (int i = 0; i < NUM_STREAMS; i++) begin
                if (busy[i]) begin
                    cnt[i] <= cnt[i] - 4'd1;
                end
            end

            // Issue-time load comes after the decrement so it wins.
            if (can_go) begin
                if (legal) begin
                    issue_valid <= 1'b1;
                    issue_instr <= hold_instr;
                    if (load_en) begin
                        cnt[load_idx] <= load_val;
                    end
                end else begin
                    illegal_op <= 1'b1;
                end
            end

            if (accept) begin
                hold_instr <= in_instr;
                hold_valid <= 1'b1;
            end else if (can_go) begin
                hold_valid <= 1'b0;
            end

            if (hold_valid && hazard && !(&stall_cycles)) begin
                stall_cycles <= stall_cycles + STALL_ONE;
            end
        end
    end

endmodule

// File: tb/tb_icu_issue_scheduler.sv
// tb_icu_issue_scheduler: directed checks of the issue scheduler.
// Ports: none; drives a main DUT and a long-latency DUT for counter saturation.
module tb_icu_issue_scheduler;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [31:0] in_instr;
    logic        in_ready;
    logic        issue_valid;
    logic [31:0] issue_instr;
    logic        illegal_op;
    logic        idle;
    logic [15:0] stall_cycles;

    logic        sat_rst;
    logic        sat_in_valid;
    logic [31:0] sat_in_instr;
    logic        sat_in_ready;
    logic        sat_issue_valid;
    logic [31:0] sat_issue_instr;
    logic        sat_illegal_op;
    logic        sat_idle;
    logic [15:0] sat_stall_cycles;

    int errors = 0;
    int checks = 0;

    localparam logic [31:0] RD_S10  = 32'h0100_1400;
    localparam logic [31:0] ADD_567 = 32'h0300_1CC5;
    localparam logic [31:0] RD_S3   = 32'h0100_0600;
    localparam logic [31:0] ADD_348 = 32'h0300_2083;
    localparam logic [31:0] ADD_D9  = 32'h0300_2400;
    localparam logic [31:0] RD_S9   = 32'h0100_1200;
    localparam logic [31:0] WR_S9   = 32'h0400_1200;
    localparam logic [31:0] BAD_OP  = 32'hFF00_0000;
    localparam logic [31:0] WR_S0   = 32'h0400_0000;

    always #5 clk = ~clk;

    icu_issue_scheduler dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_instr     (in_instr),
        .in_ready     (in_ready),
        .issue_valid  (issue_valid),
        .issue_instr  (issue_instr),
        .illegal_op   (illegal_op),
        .idle         (idle),
        .stall_cycles (stall_cycles)
    );

    icu_issue_scheduler #(.MEM_RD_LATENCY(15)) sat_dut (
        .clk          (clk),
        .rst          (sat_rst),
        .in_valid     (sat_in_valid),
        .in_instr     (sat_in_instr),
        .in_ready     (sat_in_ready),
        .issue_valid  (sat_issue_valid),
        .issue_instr  (sat_issue_instr),
        .illegal_op   (sat_illegal_op),
        .idle         (sat_idle),
        .stall_cycles (sat_stall_cycles)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (idle !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        check(tag, {31'b0, idle}, 32'd1);
    endtask

    initial begin
        rst          = 1'b1;
        in_valid     = 1'b0;
        in_instr     = '0;
        sat_rst      = 1'b1;
        sat_in_valid = 1'b1;
        sat_in_instr = RD_S3;
        tick();
        tick();
        check("rst_in_ready", {31'b0, in_ready}, 32'd1);
        check("rst_idle", {31'b0, idle}, 32'd1);
        check("rst_issue_valid", {31'b0, issue_valid}, 32'd0);
        check("rst_issue_instr", issue_instr, 32'd0);
        check("rst_illegal", {31'b0, illegal_op}, 32'd0);
        check("rst_stall", {16'b0, stall_cycles}, 32'd0);
        rst     = 1'b0;
        sat_rst = 1'b0;

        // Independent streams, back-to-back.
        in_valid = 1'b1;
        in_instr = RD_S10;
        tick();
        in_instr = ADD_567;
        check("ind_ready0", {31'b0, in_ready}, 32'd1);
        tick();
        in_valid = 1'b0;
        check("ind_iv_rd", {31'b0, issue_valid}, 32'd1);
        check("ind_ii_rd", issue_instr, RD_S10);
        check("ind_ready1", {31'b0, in_ready}, 32'd1);
        tick();
        check("ind_iv_add", {31'b0, issue_valid}, 32'd1);
        check("ind_ii_add", issue_instr, ADD_567);
        check("ind_stall", {16'b0, stall_cycles}, 32'd0);
        tick();
        check("ind_iv_off", {31'b0, issue_valid}, 32'd0);
        wait_idle("ind_idle");

        // RAW: Add waits on Read dest 3.
        in_valid = 1'b1;
        in_instr = RD_S3;
        tick();
        in_instr = ADD_348;
        tick();
        in_valid = 1'b0;
        check("raw_iv_rd", {31'b0, issue_valid}, 32'd1);
        check("raw_ii_rd", issue_instr, RD_S3);
        check("raw_ready_stall", {31'b0, in_ready}, 32'd0);
        for (int k = 0; k < 3; k++) begin
            tick();
            check("raw_iv_stall", {31'b0, issue_valid}, 32'd0);
            check("raw_ready_stall", {31'b0, in_ready}, 32'd0);
        end
        tick();
        check("raw_iv_e5", {31'b0, issue_valid}, 32'd0);
        check("raw_ready_e5", {31'b0, in_ready}, 32'd1);
        tick();
        check("raw_iv_add", {31'b0, issue_valid}, 32'd1);
        check("raw_ii_add", issue_instr, ADD_348);
        check("raw_stall", {16'b0, stall_cycles}, 32'd4);
        wait_idle("raw_idle");

        // WAW: Read 9 behind Add 9, Write 9 behind Read 9.
        in_valid = 1'b1;
        in_instr = ADD_D9;
        tick();
        in_instr = RD_S9;
        tick();
        in_instr = WR_S9;
        check("waw_iv_add", {31'b0, issue_valid}, 32'd1);
        check("waw_ii_add", issue_instr, ADD_D9);
        check("waw_ready0", {31'b0, in_ready}, 32'd0);
        for (int k = 0; k < 3; k++) begin
            tick();
            check("waw_iv_stall1", {31'b0, issue_valid}, 32'd0);
        end
        check("waw_ready_e4", {31'b0, in_ready}, 32'd1);
        tick();
        in_valid = 1'b0;
        check("waw_iv_rd", {31'b0, issue_valid}, 32'd1);
        check("waw_ii_rd", issue_instr, RD_S9);
        check("waw_ready_wr", {31'b0, in_ready}, 32'd0);
        for (int k = 0; k < 4; k++) begin
            tick();
            check("waw_iv_stall2", {31'b0, issue_valid}, 32'd0);
        end
        tick();
        check("waw_iv_wr", {31'b0, issue_valid}, 32'd1);
        check("waw_ii_wr", issue_instr, WR_S9);
        check("waw_stall", {16'b0, stall_cycles}, 32'd11);
        wait_idle("waw_idle");

        // Illegal opcode followed by a Write.
        in_valid = 1'b1;
        in_instr = BAD_OP;
        tick();
        in_instr = WR_S0;
        tick();
        in_valid = 1'b0;
        check("ill_pulse", {31'b0, illegal_op}, 32'd1);
        check("ill_no_issue", {31'b0, issue_valid}, 32'd0);
        tick();
        check("ill_pulse_off", {31'b0, illegal_op}, 32'd0);
        check("ill_iv_wr", {31'b0, issue_valid}, 32'd1);
        check("ill_ii_wr", issue_instr, WR_S0);
        check("ill_stall", {16'b0, stall_cycles}, 32'd11);
        wait_idle("ill_idle");

        // Reset while Add is stalled on stream 3.
        in_valid = 1'b1;
        in_instr = RD_S3;
        tick();
        in_instr = ADD_348;
        tick();
        in_valid = 1'b0;
        tick();
        check("mid_stall", {16'b0, stall_cycles}, 32'd12);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_idle", {31'b0, idle}, 32'd1);
        check("mid_stall_clr", {16'b0, stall_cycles}, 32'd0);
        check("mid_ready", {31'b0, in_ready}, 32'd1);
        check("mid_iv", {31'b0, issue_valid}, 32'd0);
        check("mid_ii", issue_instr, 32'd0);
        tick();
        check("mid_no_issue", {31'b0, issue_valid}, 32'd0);
        in_valid = 1'b1;
        in_instr = ADD_348;
        tick();
        in_valid = 1'b0;
        check("mid_dep_ready", {31'b0, in_ready}, 32'd1);
        tick();
        check("mid_dep_iv", {31'b0, issue_valid}, 32'd1);
        check("mid_dep_ii", issue_instr, ADD_348);
        check("mid_dep_stall", {16'b0, stall_cycles}, 32'd0);

        // Second DUT stalls 15 of every 16 cycles on repeated Read 3.
        repeat (71000) tick();
        check("sat_hold", {16'b0, sat_stall_cycles}, 32'h0000_FFFF);
        repeat (100) tick();
        check("sat_stay", {16'b0, sat_stall_cycles}, 32'h0000_FFFF);
        check("sat_no_illegal", {31'b0, sat_illegal_op}, 32'd0);
        check("sat_busy", {31'b0, sat_idle}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
